dispense_sequencer: RTL and testbench

//  Timed actuator sequencer under the main control FSM. Accepts one slot/motor request at a time via req/ack.

---
 rtl/dispense_sequencer.sv | 143 ++++++++++++++
 tb/tb_dispense_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dispense_sequencer.sv
// Timed actuator sequencer: runs one motor per request until end-of-travel or timeout,
// then enforces a motor-off cooldown; reports done with a buzzer pulse, or a sticky fault.
module dispense_sequencer #(
   parameter int unsigned RUN_MAX = 1000,
   parameter int unsigned MIN_RUN = 8,
   parameter int unsigned GAP     = 16,
   parameter int unsigned BEEP    = 50
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       req_i,
   input  logic [1:0] slot_i,
   input  logic       sensor_i,
   input  logic       fault_clr_i,
   output logic       ack_o,
   output logic       busy_o,
   output logic [3:0] motor_o,
   output logic       done_o,
   output logic       fault_o,
   output logic       buzzer_o,
   output logic       led_o
);

   localparam int unsigned CNT_MAX = (RUN_MAX > GAP) ? RUN_MAX : GAP;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam int unsigned BW      = $clog2(BEEP + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_COOL, S_FAULT} state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      slot_q;
   logic            sync1_q, sync2_q;
   logic            ack_q, busy_q, done_q, fault_q, buzzer_q;
   logic [3:0]      motor_q;
   logic [BW-1:0]   beep_q, beep_d;
   logic            run_done_c;

   // Two-flop synchroniser for the asynchronous end-of-travel switch
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sensor_i;
         sync2_q <= sync1_q;
      end
   end

   // Sensor only counts once the spin-up blanking window has elapsed
   assign run_done_c = (state_q == S_RUN) && sync2_q && (cnt_q >= CW'(MIN_RUN));

   always_comb begin
      beep_d = beep_q;
      if (beep_q != '0) beep_d = beep_q - BW'(1);
      if (run_done_c)   beep_d = BW'(BEEP);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         beep_q   <= '0;
         buzzer_q <= 1'b0;
      end else begin
         beep_q   <= beep_d;
         buzzer_q <= (beep_d != '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         slot_q  <= 2'd0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         motor_q <= 4'b0000;
      end else begin
         ack_q  <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_i) begin
                  state_q <= S_RUN;
                  slot_q  <= slot_i;
                  cnt_q   <= '0;
                  ack_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  motor_q <= 4'(1) << slot_i;
               end
            end
            S_RUN: begin
               // Sensor takes priority over a coincident timeout
               if (run_done_c) begin
                  state_q <= S_COOL;
                  cnt_q   <= '0;
                  done_q  <= 1'b1;
                  motor_q <= 4'b0000;
               end else if (cnt_q == CW'(RUN_MAX - 1)) begin
                  state_q <= S_FAULT;
                  cnt_q   <= '0;
                  fault_q <= 1'b1;
                  motor_q <= 4'b0000;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
                  motor_q <= 4'(1) << slot_q;
               end
            end
            S_COOL: begin
               if (cnt_q == CW'(GAP - 1)) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_FAULT: begin
               if (fault_clr_i) begin
                  state_q <= S_COOL;
                  cnt_q   <= '0;
                  fault_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               motor_q <= 4'b0000;
            end
         endcase
      end
   end

   assign ack_o    = ack_q;
   assign busy_o   = busy_q;
   assign motor_o  = motor_q;
   assign done_o   = done_q;
   assign fault_o  = fault_q;
   assign buzzer_o = buzzer_q;
   assign led_o    = fault_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer: cycle model of the sequencing rules plus directed runs.
module tb_dispense_sequencer;

   localparam int RUN_MAX = 1000;
   localparam int MIN_RUN = 8;
   localparam int GAP     = 16;
   localparam int BEEP    = 50;

   logic       clk = 1'b0;
   logic       reset_i = 1'b1;
   logic       req_i = 1'b0;
   logic [1:0] slot_i = 2'd0;
   logic       sensor_i = 1'b0;
   logic       fault_clr_i = 1'b0;
   logic       ack_o, busy_o, done_o, fault_o, buzzer_o, led_o;
   logic [3:0] motor_o;

   dispense_sequencer #(.RUN_MAX(RUN_MAX), .MIN_RUN(MIN_RUN), .GAP(GAP), .BEEP(BEEP)) dut (
      .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .slot_i(slot_i), .sensor_i(sensor_i),
      .fault_clr_i(fault_clr_i), .ack_o(ack_o), .busy_o(busy_o), .motor_o(motor_o),
      .done_o(done_o), .fault_o(fault_o), .buzzer_o(buzzer_o), .led_o(led_o));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: mode 0 idle, 1 run, 2 cool, 3 fault; countdowns instead of shared counter
   int         m_mode = 0, m_run = 0, m_cool = 0, m_beep = 0;
   logic [1:0] m_slot = 2'd0;
   bit         m_s1 = 0, m_s2 = 0, m_ack = 0, m_done = 0;

   always @(posedge clk) begin
      bit sens;
      if (reset_i) begin
         m_mode = 0; m_run = 0; m_cool = 0; m_beep = 0; m_slot = 2'd0;
         m_s1 = 0; m_s2 = 0; m_ack = 0; m_done = 0;
      end else begin
         sens = m_s2;
         m_s2 = m_s1;
         m_s1 = sensor_i;
         m_ack = 0;
         m_done = 0;
         if (m_beep > 0) m_beep--;
         case (m_mode)
            0: if (req_i) begin m_mode = 1; m_slot = slot_i; m_run = 0; m_ack = 1; end
            1: begin
               if (sens && m_run >= MIN_RUN) begin
                  m_mode = 2; m_cool = GAP; m_done = 1; m_beep = BEEP;
               end else if (m_run == RUN_MAX - 1) m_mode = 3;
               else m_run++;
            end
            2: begin m_cool--; if (m_cool == 0) m_mode = 0; end
            default: if (fault_clr_i) begin m_mode = 2; m_cool = GAP; end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ack", int'(ack_o), int'(m_ack));
         chk("busy", int'(busy_o), int'(m_mode != 0));
         chk("motor", int'(motor_o), (m_mode == 1) ? (1 << m_slot) : 0);
         chk("done", int'(done_o), int'(m_done));
         chk("fault", int'(fault_o), int'(m_mode == 3));
         chk("led", int'(led_o), int'(m_mode == 3));
         chk("buzzer", int'(buzzer_o), int'(m_beep > 0));
         chk("onehot", int'($countones(motor_o) <= 1), 1);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   // Issue a request, then count motor-on cycles; sensor pin driven by RUN cycle index
   task automatic do_run(input logic [1:0] s, input int sense_at, input int glitch_at,
                         input bit hold_req, output int mc);
      int cyc;
      req_i  = 1'b1;
      slot_i = s;
      for (int i = 0; i < 200; i++) begin
         if (ack_o) break;
         step();
      end
      chk("run_ack", int'(ack_o), 1);
      chk("run_motor_onehot", int'(motor_o), 1 << s);
      if (!hold_req) req_i = 1'b0;
      mc = 0;
      for (int i = 0; i < RUN_MAX + 20; i++) begin
         if (motor_o == 4'b0000) break;
         mc++;
         cyc = mc - 1;
         sensor_i = ((sense_at >= 0) && (cyc >= sense_at)) || (cyc == glitch_at);
         step();
      end
      sensor_i = 1'b0;
   endtask

   initial begin
      int mc, cc, bc, gap;
      step();
      step();
      chk_en = 1'b1;
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_motor", int'(motor_o), 0);
      reset_i = 1'b0;
      step();

      // 1: slot 2, sensor at RUN cycle 20 -> done after 2-flop sync
      do_run(2'd2, 20, -1, 1'b0, mc);
      chk("t1_motor_len", mc, 23);
      chk("t1_done", int'(done_o), 1);
      cc = 0; bc = 0;
      for (int i = 0; i < 200; i++) begin
         if (busy_o) cc++;
         if (buzzer_o) bc++;
         if (!busy_o && !buzzer_o) break;
         step();
      end
      chk("t1_cool_len", cc, 16);
      chk("t1_buzz_len", bc, 50);

      // 2: glitch during blanking ignored, run ends on second event
      do_run(2'd1, 30, 3, 1'b0, mc);
      chk("t2_motor_len", mc, 33);
      chk("t2_done", int'(done_o), 1);
      repeat (20) step();

      // 3: timeout -> fault, req ignored, fault_clr -> cooldown
      do_run(2'd0, -1, -1, 1'b0, mc);
      chk("t3_motor_len", mc, 1000);
      chk("t3_fault", int'(fault_o), 1);
      chk("t3_led", int'(led_o), 1);
      chk("t3_nodone", int'(done_o), 0);
      req_i = 1'b1;
      repeat (5) step();
      chk("t3_fault_hold", int'(fault_o), 1);
      req_i = 1'b0;
      fault_clr_i = 1'b1;
      step();
      fault_clr_i = 1'b0;
      chk("t3_fault_clr", int'(fault_o), 0);
      cc = 0;
      for (int i = 0; i < 100; i++) begin
         if (!busy_o) break;
         cc++;
         step();
      end
      chk("t3_cool_len", cc, 16);
      repeat (40) step();

      // 4: sensor_s arrives on the last RUN cycle -> done wins
      do_run(2'd3, RUN_MAX - 3, -1, 1'b0, mc);
      chk("t4_motor_len", mc, 1000);
      chk("t4_done", int'(done_o), 1);
      chk("t4_nofault", int'(fault_o), 0);
      repeat (80) step();

      // 5: req held high across two runs
      do_run(2'd1, 10, -1, 1'b1, mc);
      chk("t5_done1", int'(done_o), 1);
      gap = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         gap++;
         if (ack_o) break;
      end
      chk("t5_ack_gap", gap, 17);
      do_run(2'd1, 10, -1, 1'b1, mc);
      chk("t5_done2", int'(done_o), 1);
      chk("t5_motor_len", mc, 13);

      // 6: reset mid-RUN on slot 3 while buzzer still sounding
      slot_i = 2'd3;
      for (int i = 0; i < 100; i++) begin
         if (ack_o) break;
         step();
      end
      chk("t6_ack", int'(ack_o), 1);
      req_i = 1'b0;
      repeat (10) step();
      chk("t6_motor_pre", int'(motor_o), 8);
      chk("t6_buzz_pre", int'(buzzer_o), 1);
      reset_i = 1'b1;
      step();
      chk("t6_motor", int'(motor_o), 0);
      chk("t6_busy", int'(busy_o), 0);
      chk("t6_buzzer", int'(buzzer_o), 0);
      chk("t6_done", int'(done_o), 0);
      chk("t6_fault", int'(fault_o), 0);
      reset_i = 1'b0;
      repeat (5) step();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
